// File: rtl/axi4_bram_slave.sv
// axi4_bram_slave: AXI4 slave serialising read/write bursts onto one single-port block RAM
module axi4_bram_slave #(
  parameter int          MEM_BYTES = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          ID_W      = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [ID_W-1:0] S_AXI_AWID,
  input  logic [63:0]     S_AXI_AWADDR,
  input  logic [7:0]      S_AXI_AWLEN,
  input  logic [2:0]      S_AXI_AWSIZE,
  input  logic [1:0]      S_AXI_AWBURST,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [63:0]     S_AXI_WDATA,
  input  logic [7:0]      S_AXI_WSTRB,
  input  logic            S_AXI_WLAST,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [ID_W-1:0] S_AXI_BID,
  output logic [1:0]      S_AXI_BRESP,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [ID_W-1:0] S_AXI_ARID,
  input  logic [63:0]     S_AXI_ARADDR,
  input  logic [7:0]      S_AXI_ARLEN,
  input  logic [2:0]      S_AXI_ARSIZE,
  input  logic [1:0]      S_AXI_ARBURST,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [ID_W-1:0] S_AXI_RID,
  output logic [63:0]     S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RLAST,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY
);
  localparam int WORDS = MEM_BYTES / 8;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [1:0] B_FIXED = 2'd0, B_INCR = 2'd1, B_WRAP = 2'd2;
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_BURST} state_t;
  state_t state, state_n;
  logic [63:0] addr_q, nxt_addr, step, wmask, off;
  logic [7:0] len_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [ID_W-1:0] id_q;
  logic [8:0] cnt;
  logic err_q, last_rd;
  logic ar_gnt, aw_gnt, w_hs, w_fin, b_hs, r_pop, r_done, r_iss, oor, at_len;
  logic [63:0] a_addr;
  logic [7:0] a_len;
  logic [2:0] a_size, a_sz;
  logic [1:0] a_burst, a_bt;
  logic [ID_W-1:0] a_id;
  logic [IW-1:0] idx;
  logic [63:0] mem [WORDS];
  logic [63:0] ram_q;
  logic p_v, p_err, p_last;
  logic [63:0] f_data [2];
  logic [1:0] f_resp [2];
  logic f_last [2];
  logic f_wp, f_rp;
  logic [1:0] f_cnt;
  assign ar_gnt = state == IDLE && !rst_i && S_AXI_ARVALID && (!S_AXI_AWVALID || !last_rd);
  assign aw_gnt = state == IDLE && !rst_i && S_AXI_AWVALID && !ar_gnt;
  assign a_addr = ar_gnt ? S_AXI_ARADDR : S_AXI_AWADDR;
  assign a_len = ar_gnt ? S_AXI_ARLEN : S_AXI_AWLEN;
  assign a_size = ar_gnt ? S_AXI_ARSIZE : S_AXI_AWSIZE;
  assign a_burst = ar_gnt ? S_AXI_ARBURST : S_AXI_AWBURST;
  assign a_id = ar_gnt ? S_AXI_ARID : S_AXI_AWID;
  assign a_sz = a_size[2] ? 3'd3 : a_size;
  assign a_bt = a_burst == 2'b00 ? B_FIXED :
                (a_burst == 2'b10 && (a_len == 8'd1 || a_len == 8'd3 || a_len == 8'd7 || a_len == 8'd15)) ? B_WRAP : B_INCR;
  assign step = 64'd1 << size_q;
  assign wmask = ((64'(len_q) + 64'd1) << size_q) - 64'd1;
  assign nxt_addr = burst_q == B_FIXED ? addr_q :
                    burst_q == B_WRAP ? (addr_q & ~wmask) | ((addr_q + step) & wmask) : addr_q + step;
  assign off = addr_q - BASE_ADDR;
  assign oor = addr_q < BASE_ADDR || off >= 64'(MEM_BYTES);
  assign idx = IW'(off >> 3);
  assign at_len = cnt == {1'b0, len_q};
  assign w_hs = state == WR_DATA && S_AXI_WVALID;
  assign w_fin = w_hs && at_len;
  assign b_hs = state == WR_RESP && S_AXI_BREADY;
  assign r_pop = f_cnt != 2'd0 && S_AXI_RREADY;
  assign r_done = r_pop && f_last[f_rp];
  assign r_iss = state == RD_BURST && cnt <= {1'b0, len_q} &&
                 ({1'b0, f_cnt} + {2'b0, p_v} - {2'b0, r_pop}) < 3'd2;
  assign S_AXI_AWREADY = aw_gnt;
  assign S_AXI_ARREADY = ar_gnt;
  assign S_AXI_WREADY = state == WR_DATA;
  assign S_AXI_BVALID = state == WR_RESP;
  assign S_AXI_BID = id_q;
  assign S_AXI_BRESP = err_q ? 2'b10 : 2'b00;
  assign S_AXI_RID = id_q;
  assign S_AXI_RVALID = f_cnt != 2'd0;
  assign S_AXI_RDATA = f_data[f_rp];
  assign S_AXI_RRESP = f_resp[f_rp];
  assign S_AXI_RLAST = f_last[f_rp];
  // next-state selection for the shared read/write sequencer
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = ar_gnt ? RD_BURST : aw_gnt ? WR_DATA : IDLE;
      WR_DATA:  state_n = w_fin ? WR_RESP : WR_DATA;
      WR_RESP:  state_n = b_hs ? IDLE : WR_RESP;
      RD_BURST: state_n = r_done ? IDLE : RD_BURST;
      default:  state_n = IDLE;
    endcase
  end
  // byte-enabled write and registered read on the single RAM port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_hs && !oor && !rst_i)
      for (int i = 0; i < 8; i++)
        if (S_AXI_WSTRB[i]) mem[idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
    ram_q <= mem[idx];
  end
  // burst context, beat address/counter and write error accumulation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= B_INCR;
      id_q <= '0;
      cnt <= '0;
      err_q <= 1'b0;
      last_rd <= 1'b0;
    end else begin
      state <= state_n;
      if (ar_gnt || aw_gnt) begin
        addr_q <= a_addr & ~((64'd1 << a_sz) - 64'd1);
        len_q <= a_len;
        size_q <= a_sz;
        burst_q <= a_bt;
        id_q <= a_id;
        cnt <= '0;
        err_q <= 1'b0;
        last_rd <= ar_gnt;
      end
      if (w_hs || r_iss) begin
        addr_q <= nxt_addr;
        cnt <= cnt + 9'd1;
      end
      if (w_hs) err_q <= err_q | oor | (S_AXI_WLAST != at_len);
    end
  end
  // RAM-latency stage feeding a 2-entry output FIFO; issue is credit-limited so nothing overflows
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_v <= 1'b0;
      p_err <= 1'b0;
      p_last <= 1'b0;
      f_wp <= 1'b0;
      f_rp <= 1'b0;
      f_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_resp[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      p_v <= r_iss;
      p_err <= oor;
      p_last <= at_len;
      if (p_v) begin
        f_data[f_wp] <= p_err ? 64'd0 : ram_q;
        f_resp[f_wp] <= p_err ? 2'b10 : 2'b00;
        f_last[f_wp] <= p_last;
        f_wp <= ~f_wp;
      end
      if (r_pop) f_rp <= ~f_rp;
      f_cnt <= f_cnt + {1'b0, p_v} - {1'b0, r_pop};
    end
  end
endmodule

// File: doc/axi4_bram_slave.md
Name: axi4_bram_slave

Overview:
- AXI4 slave that terminates the core's 64-bit AXI4 master port and backs it with an inferred single-port block RAM.
- Sits directly downstream of the core wrapper: boot ROM/scratch RAM for FPGA bring-up.
- Serialises read and write bursts onto one RAM port.
- Supports FIXED, INCR and WRAP bursts of 1–256 beats.

Parameters:
- MEM_BYTES, 65536: RAM size in bytes; power of two, at least 8.
- BASE_ADDR, 64'h8000_0000: byte address mapped to RAM word 0.
- ID_W, 4: AXI ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- S_AXI_AWID  in  ID_W  write ID
- S_AXI_AWADDR  in  64  write address
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWSIZE  in  3  bytes/beat log2
- S_AXI_AWBURST  in  2  burst type
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  64
- S_AXI_WSTRB  in  8  byte enables
- S_AXI_WLAST  in  1
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BID  out  ID_W
- S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARID  in  ID_W
- S_AXI_ARADDR  in  64
- S_AXI_ARLEN  in  8
- S_AXI_ARSIZE  in  3
- S_AXI_ARBURST  in  2
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RID  out  ID_W
- S_AXI_RDATA  out  64
- S_AXI_RRESP  out  2
- S_AXI_RLAST  out  1
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - All READY/VALID outputs go to 0; IDs, RESP, RDATA and RLAST go to 0; FSM returns to IDLE.
  - Any burst in flight is abandoned; no partial RAM write completes after reset.
  - RAM contents are preserved.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_BURST.
- IDLE, both AWVALID and ARVALID high: grant the channel not granted last time (round-robin; reads win on the first conflict after reset).
- Address acceptance: AWREADY or ARREADY pulses for exactly one cycle in IDLE; address, len, size, burst and ID are latched.
- Beat address: beat n address is the start address aligned down to 2^SIZE.
  - INCR: add 2^SIZE per beat.
  - FIXED: address constant.
  - WRAP: wrap inside a (LEN+1)*2^SIZE window. Only LEN 1, 3, 7 or 15 is legal for WRAP; any other LEN is treated as INCR.
  - Burst type 2'b11 is treated as INCR.
  - SIZE above 3 is treated as 3.
- RAM index is (addr - BASE_ADDR)[log2(MEM_BYTES)-1:3].
- Range check: a beat is out of range if addr < BASE_ADDR or addr >= BASE_ADDR + MEM_BYTES.
  - Writes: out-of-range beats are not written, and the burst's BRESP is SLVERR (2'b10) if any beat was out of range, else OKAY.
  - Reads: out-of-range beats return RDATA 0 with RRESP SLVERR; in-range beats return OKAY.
- WR_DATA:
  - WREADY is 1.
  - Each W handshake writes the bytes enabled by WSTRB on the same edge.
  - The beat counter moves to WR_RESP on the beat where count == LEN. It does not wait for WLAST.
  - A WLAST/count mismatch forces BRESP SLVERR.
- WR_RESP:
  - BVALID is 1 with the latched ID and BID.
  - BVALID stays high until BREADY; on the handshake, go to IDLE.
- RD_BURST:
  - RAM read latency is 1 cycle.
  - A 2-entry output skid buffer gives 1 beat/cycle sustained throughput while RREADY is held high.
  - RDATA, RRESP and RLAST stay stable while RVALID is high and RREADY is low.
  - RLAST is set on beat LEN.
  - After the RLAST handshake, go to IDLE.
- Latency:
  - First RVALID rises 2 cycles after the AR handshake.
  - BVALID rises 1 cycle after the final W handshake.
- Single outstanding transaction; no address is accepted outside IDLE.
- W beats presented before the AW handshake are held off, because WREADY is 0.

Test Plan:
- AW 0x8000_0000, LEN 3, INCR, SIZE 3, data 0x11..0x44, full strobes; then AR same address -> RDATA 0x11, 0x22, 0x33, 0x44; RLAST on beat 4; BRESP and RRESP OKAY; RID and BID equal the issued IDs.
- Write WSTRB 8'h0F of 0xFFFF_FFFF_FFFF_FFFF over 0x0; read back -> 0x0000_0000_FFFF_FFFF.
- AR 0x8000_0018, LEN 3, WRAP, after preloading words 0–3 with 0,1,2,3 -> RDATA order 3, 0, 1, 2.
- RREADY toggling 1-0-0-1 during an 8-beat INCR read -> no beat lost or duplicated; RDATA stable while stalled; throughput 1 beat/cycle once RREADY is held high.
- AWVALID and ARVALID raised in the same cycle, twice in a row -> first grant is read, second is write.
- AW 0x7FFF_FFF8, LEN 1 -> beat 0 dropped, beat 1 written to word 0, BRESP SLVERR.
- Assert rst_i mid 16-beat read -> next cycle RVALID 0 and FSM in IDLE; a new AR is accepted with correct data.
